// File: rtl/slice_add_sequencer_if.sv
// Operand/result handshake bundle for slice_add_sequencer.
// master = producer/consumer side, slave = sequencer.
interface slice_add_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/slice_add_sequencer.sv
// Multi-cycle WIDTH-bit adder sharing one SLICE-bit CLA slice.
// Define SLICE_ADD_SUB_EN to honour op=1 as subtract.
module slice_add_sequencer #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input logic clk,
   input logic rst,
   slice_add_sequencer_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int NGRP   = SLICE / 4;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] ss;
   logic             sco;
   logic [3:0]       gg;
   logic [3:0]       pp;
   logic [4:0]       cc;
   logic             last;

   assign last = (cnt_q == CW'(NSLICE - 1));

   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) begin
            sa = a_q[i*SLICE +: SLICE];
            sb = b_q[i*SLICE +: SLICE];
         end
      end
   end

   // 4-bit lookahead groups; group carries chain between groups
   always_comb begin
      ss = '0;
      gg = '0;
      pp = '0;
      cc = '0;
      cc[0] = carry_q;
      for (int g = 0; g < NGRP; g++) begin
         gg = sa[g*4 +: 4] & sb[g*4 +: 4];
         pp = sa[g*4 +: 4] ^ sb[g*4 +: 4];
         cc[1] = gg[0] | (pp[0] & cc[0]);
         cc[2] = gg[1] | (pp[1] & gg[0])
               | (pp[1] & pp[0] & cc[0]);
         cc[3] = gg[2] | (pp[2] & gg[1])
               | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & cc[0]);
         cc[4] = gg[3] | (pp[3] & gg[2])
               | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0])
               | (&pp & cc[0]);
         ss[g*4 +: 4] = pp ^ cc[3:0];
         cc[0] = cc[4];
      end
      sco = cc[0];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt_q <= '0;
                  a_q   <= bus.a;
`ifdef SLICE_ADD_SUB_EN
                  b_q     <= bus.op ? ~bus.b : bus.b;
                  carry_q <= bus.op | bus.cin;
`else
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
`endif
               end
            end
            RUN: begin
               carry_q <= sco;
               for (int i = 0; i < NSLICE; i++) begin
                  if (cnt_q == CW'(i))
                     sum_q[i*SLICE +: SLICE] <= ss;
               end
               if (last) cout_q <= sco;
               else      cnt_q  <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_slice_add_sequencer.sv
// Randomised self-checking bench for slice_add_sequencer.
// Reference result is plain (WIDTH+1)-bit arithmetic.
module tb_slice_add_sequencer;
   localparam int W      = 64;
   localparam int S      = 16;
   localparam int NSLICE = W / S;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;

   slice_add_sequencer_if #(.WIDTH(W)) bus ();

   slice_add_sequencer #(
      .WIDTH(W),
      .SLICE(S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag,
                        input logic [W:0] got,
                        input logic [W:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic cin,
                                        input logic op);
      logic [W-1:0] bb;
      logic         c;
      bb = b;
      c  = cin;
`ifdef SLICE_ADD_SUB_EN
      if (op) begin
         bb = ~b;
         c  = 1'b1;
      end
`endif
      return {1'b0, a} + {1'b0, bb} + (W + 1)'(c);
   endfunction

   function automatic logic [W-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic do_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic tc,
                        input logic to,
                        input int bp);
      logic [W:0] e;
      int         n;
      e = model(ta, tb, tc, to);
      bus.out_ready = 1'b0;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_idle", W'(bus.in_ready), 1);
      bus.a        = ta;
      bus.b        = tb;
      bus.cin      = tc;
      bus.op       = to;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = rnd64();
      bus.b        = rnd64();
      bus.cin      = 1'($urandom());
      bus.op       = 1'($urandom());
      check("busy_run", W'(bus.busy), 1);
      check("in_ready_run", W'(bus.in_ready), 0);
      n = 1;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      check("latency", W'(n), W'(NSLICE + 1));
      check("sum", {1'b0, bus.sum}, {1'b0, e[W-1:0]});
      check("cout", W'(bus.cout), W'(e[W]));
      for (int k = 0; k < bp; k++) begin
         bus.in_valid = 1'($urandom());
         tick();
         check("hold_valid", W'(bus.out_valid), 1);
         check("hold_sum", {1'b0, bus.sum}, {1'b0, e[W-1:0]});
         check("hold_cout", W'(bus.cout), W'(e[W]));
         check("hold_in_ready", W'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("release_valid", W'(bus.out_valid), 0);
      check("release_in_ready", W'(bus.in_ready), 1);
   endtask

   initial begin
      logic [W:0]   e1;
      logic [W:0]   e2;
      logic         acc;
      int           nacc;
      int           nres;
      int           t1;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.op        = 1'b0;
      tick();
      tick();
      check("rst_in_ready", W'(bus.in_ready), 1);
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_busy", W'(bus.busy), 0);
      check("rst_sum", {1'b0, bus.sum}, 0);
      check("rst_cout", W'(bus.cout), 0);
      rst = 1'b0;

      // carry ripple through every slice
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
      do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
      do_op(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 0);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1);
      // backpressure for 10 cycles with in_valid noise
      do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
            1'b1, 1'b0, 10);
      do_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
      do_op(64'd7, 64'd5, 1'b0, 1'b1, 0);
      do_op(64'd5, 64'd7, 1'b1, 1'b1, 0);

      // reset in RUN at T2
      bus.a        = rnd64();
      bus.b        = rnd64();
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready", W'(bus.in_ready), 1);
      check("abort_out_valid", W'(bus.out_valid), 0);
      check("abort_busy", W'(bus.busy), 0);
      check("abort_sum", {1'b0, bus.sum}, 0);
      check("abort_cout", W'(bus.cout), 0);
      do_op(64'd3, 64'd4, 1'b0, 1'b0, 0);

      // back-to-back: second pair held during RUN
      e1 = model(64'hAAAA_0000_5555_FFFF, 64'h1111_2222_3333_0001,
                 1'b0, 1'b0);
      e2 = model(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F1,
                 1'b0, 1'b0);
      bus.a         = 64'hAAAA_0000_5555_FFFF;
      bus.b         = 64'h1111_2222_3333_0001;
      bus.cin       = 1'b0;
      bus.op        = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      nacc = 0;
      nres = 0;
      t1   = 0;
      for (int k = 0; k < 40 && nres < 2; k++) begin
         acc = bus.in_ready && bus.in_valid;
         tick();
         if (acc) begin
            nacc++;
            if (nacc == 1) begin
               bus.a = 64'h0F0F_0F0F_0F0F_0F0F;
               bus.b = 64'hF0F0_F0F0_F0F0_F0F1;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid) begin
            nres++;
            if (nres == 1) begin
               check("b2b_sum1", {bus.cout, bus.sum}, e1);
               t1 = cyc;
            end else begin
               check("b2b_sum2", {bus.cout, bus.sum}, e2);
               check("b2b_spacing", W'(cyc - t1), W'(NSLICE + 2));
            end
         end
      end
      check("b2b_results", W'(nres), 2);
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;

      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = rnd64();
         rb = rnd64();
         if ($urandom_range(0, 7) == 0) ra = '1;
         if ($urandom_range(0, 7) == 0) rb = ~ra;
         do_op(ra, rb, 1'($urandom()), 1'($urandom()),
               $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/slice_add_sequencer.md
Name: slice_add_sequencer

Overview:
- Multi-cycle controller for a WIDTH-bit add.
- Time-shares one SLICE-bit carry-lookahead adder slice, built from 4-bit CLA groups, across WIDTH/SLICE cycles.
- A carry register chains the slices; a result register assembles the full sum.
- Sits between an operand producer and a result consumer. Uses valid/ready handshakes on both sides, in place of a fully spatial 64-bit adder when area matters more than latency.

Parameters:
WIDTH, 64, operand/result width; must be an integer multiple of SLICE
SLICE, 16, width of the shared adder slice; multiple of 4
NSLICE, WIDTH/SLICE (derived localparam), number of slice iterations

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to slice 0
op  input  1  0 = add, 1 = subtract (only honoured with SUB_EN)
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of the top slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: synchronous and active-high on clk. The clock is clk and the reset is rst.
  - State goes to IDLE.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
  - Slice counter, carry register and operand registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture a, b, cin and op. Clear the slice counter, load the carry register with the effective cin, and go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle i (counter 0..NSLICE-1), the slice adds A[i*SLICE +: SLICE] and B'[i*SLICE +: SLICE] with the carry register.
  - The slice sum is written to sum[i*SLICE +: SLICE] and the slice carry-out to the carry register.
  - When the counter reaches NSLICE-1: latch cout from the final slice carry and go to DONE. Otherwise increment the counter.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - When out_ready=1: out_valid goes to 0 next cycle and the state returns to IDLE.
  - in_ready stays 0 in DONE. No same-cycle accept on the result handshake; the next operand is accepted at the earliest in the cycle after return to IDLE.
- Latency:
  - Accept edge at cycle T0; RUN occupies T1..T_NSLICE; out_valid is first high in cycle T_NSLICE+1 (T5 for the defaults).
  - Minimum issue interval is NSLICE+2 cycles.
- Sum/partial visibility:
  - sum is only architecturally valid while out_valid=1.
  - Partially written slices may be visible during RUN.
  - sum keeps its old value after DONE until the next RUN overwrites it.
- Control rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - Operand inputs are don't-care after capture.
- Arithmetic: modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Reset mid-operation (RUN or DONE): abort immediately to the reset values; any pending result is discarded.
- Reset overrides in_valid/out_ready in the same cycle.

Optional Feature:
SLICE_ADD_SUB_EN
- Defined:
  - op=1 selects subtract: B' = ~b and effective carry-in = 1, so sum = a - b with cin ignored.
  - cout=1 means no borrow.
- Not defined:
  - op is ignored; B' = b and effective carry-in = cin.
  - No inversion logic is synthesised.

Test Plan:
1. Full carry ripple: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0 accepted at T0 -> out_valid first high at T5, sum=0, cout=1.
2. Inter-slice carry: a=0000_0000_0000_FFFF, b=0000_0000_0000_0001, cin=0 -> sum=0000_0000_0001_0000, cout=0. Repeat with cin=1 and b=0 -> same sum.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and cout stay stable and in_ready=0; in_valid pulses are ignored. Then out_ready=1 for one cycle -> IDLE with in_ready=1.
4. Back-to-back: second operand pair presented during RUN is not captured. It is accepted only after return to IDLE; two results arrive in order with 6-cycle spacing.
5. Reset in RUN at T2 -> next cycle state IDLE, out_valid=0, sum=0, cout=0, in_ready=1. A fresh add of 3+4 then gives sum=7.
6. (SLICE_ADD_SUB_EN) a=5, b=7, op=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0. a=7, b=5, op=1 -> sum=2, cout=1. Without the macro, op=1 with a=5, b=7, cin=0 -> sum=12.
